// File: rtl/zap_register_file.sv
// ----------------------------------------------------------------------------
// zap_register_file
// Physical general-purpose register file of the ZAP core (writeback stage).
// Holds every banked ARM register plus the RAZ dump entry; PC and CPSR live
// elsewhere.
//
// Ports
//   i_clk          core clock, all state changes on its rising edge
//   i_reset        synchronous active-high reset, clears every entry to 0
//   i_wr_addr_a/b  write port A/B address
//   i_wr_data_a/b  write port A/B data
//   i_wen          write enable shared by ports A and B
//   i_rd_addr_a..d read port A..D address
//   o_rd_data_a..d read port A..D data (combinational, zero latency)
//
// Write collisions resolve in favour of port B. Addresses >= PHY_REGS are
// dropped on writes (per port) and read back as 0. Reads see the contents
// before the edge; there is no write-to-read bypass.
// ----------------------------------------------------------------------------
module zap_register_file #(
    parameter int unsigned PHY_REGS = 46,
    localparam int unsigned AW      = $clog2(PHY_REGS)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [AW-1:0] i_wr_addr_a,
    input  logic [AW-1:0] i_wr_addr_b,
    input  logic [31:0]   i_wr_data_a,
    input  logic [31:0]   i_wr_data_b,
    input  logic          i_wen,
    input  logic [AW-1:0] i_rd_addr_a,
    input  logic [AW-1:0] i_rd_addr_b,
    input  logic [AW-1:0] i_rd_addr_c,
    input  logic [AW-1:0] i_rd_addr_d,
    output logic [31:0]   o_rd_data_a,
    output logic [31:0]   o_rd_data_b,
    output logic [31:0]   o_rd_data_c,
    output logic [31:0]   o_rd_data_d
);

    localparam int unsigned DW = 32;

    logic [DW-1:0] regs [PHY_REGS];

    logic wr_ok_a;
    logic wr_ok_b;

    // Per-port range qualification: an out-of-range port is dropped alone.
    always_comb begin
        wr_ok_a = (32'(i_wr_addr_a) < PHY_REGS);
        wr_ok_b = (32'(i_wr_addr_b) < PHY_REGS);
    end

    // Storage update; port B is assigned last so it wins on a collision.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            regs <= '{default: '0};
        end else if (i_wen) begin
            if (wr_ok_a) begin
                regs[i_wr_addr_a] <= i_wr_data_a;
            end
            if (wr_ok_b) begin
                regs[i_wr_addr_b] <= i_wr_data_b;
            end
        end
    end

    // Range-checked read; addresses past the last entry return 0.
    function automatic logic [DW-1:0] read_entry(input logic [AW-1:0] addr);
        logic [DW-1:0] val;
        val = '0;
        if (32'(addr) < PHY_REGS) begin
            val = regs[addr];
        end
        return val;
    endfunction

    // Four independent asynchronous read ports.
    always_comb begin
        o_rd_data_a = read_entry(i_rd_addr_a);
        o_rd_data_b = read_entry(i_rd_addr_b);
        o_rd_data_c = read_entry(i_rd_addr_c);
        o_rd_data_d = read_entry(i_rd_addr_d);
    end

endmodule

// File: tb/tb_zap_register_file.sv
// ----------------------------------------------------------------------------
// tb_zap_register_file
// Self-checking bench for zap_register_file: a directed vector table, a
// read-during-write sequence, and randomized traffic against a flat array
// model of the register file.
// ----------------------------------------------------------------------------
module tb_zap_register_file;

    localparam int unsigned NREGS = 46;
    localparam int unsigned AW    = 6;
    localparam int unsigned SPAN  = 1 << AW;

    logic          clk;
    logic          rst;
    logic [AW-1:0] wa, wb, ra, rb, rc, rd;
    logic [31:0]   da, db;
    logic          wen;
    logic [31:0]   qa, qb, qc, qd;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: every addressable slot; slots >= NREGS are never written.
    logic [31:0] model [SPAN];

    zap_register_file #(.PHY_REGS(NREGS)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_wr_addr_a (wa),
        .i_wr_addr_b (wb),
        .i_wr_data_a (da),
        .i_wr_data_b (db),
        .i_wen       (wen),
        .i_rd_addr_a (ra),
        .i_rd_addr_b (rb),
        .i_rd_addr_c (rc),
        .i_rd_addr_d (rd),
        .o_rd_data_a (qa),
        .o_rd_data_b (qb),
        .o_rd_data_c (qc),
        .o_rd_data_d (qd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          reset;
        logic          wen;
        logic [AW-1:0] wa;
        logic [AW-1:0] wb;
        logic [31:0]   da;
        logic [31:0]   db;
        logic [AW-1:0] ra, rb, rc, rd;
        logic [31:0]   ea, eb, ec, ed;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(SPAN); i++) model[i] = '0;
    endtask

    // Spec-level write rule applied at a rising edge.
    task automatic model_edge();
        if (rst) begin
            model_clear();
        end else if (wen) begin
            if (32'(wa) < NREGS) model[wa] = da;
            if (32'(wb) < NREGS) model[wb] = db;
        end
    endtask

    task automatic chk_model(input string name);
        chk({name, "_a"}, qa, model[ra]);
        chk({name, "_b"}, qb, model[rb]);
        chk({name, "_c"}, qc, model[rc]);
        chk({name, "_d"}, qd, model[rd]);
    endtask

    // Drive write inputs away from the edge, take one edge, keep the model in step.
    task automatic do_edge(input logic r, input logic w,
                           input logic [AW-1:0] a_addr, input logic [31:0] a_data,
                           input logic [AW-1:0] b_addr, input logic [31:0] b_data);
        @(negedge clk);
        rst = r; wen = w; wa = a_addr; da = a_data; wb = b_addr; db = b_data;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_reads(input logic [AW-1:0] a, input logic [AW-1:0] b,
                             input logic [AW-1:0] c, input logic [AW-1:0] d);
        ra = a; rb = b; rc = c; rd = d;
        #1;
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; wa = '0; wb = '0; da = '0; db = '0;
        ra = '0; rb = '0; rc = '0; rd = '0;
        model_clear();

        // Directed table: {reset, wen, wa, wb, da, db, reads, expected reads}
        vecs[0] = '{1'b0, 1'b1, 6'd5,  6'd45, 32'hDEADBEEF, 32'h0,
                    6'd5,  6'd45, 6'd0,  6'd1,
                    32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 6'd5,  6'd45, 32'hCAFEF00D, 32'h77,
                    6'd5,  6'd5,  6'd45, 6'd45,
                    32'h0, 32'h0, 32'h0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 6'd3,  6'd40, 32'h11111111, 32'h22222222,
                    6'd3,  6'd40, 6'd5,  6'd0,
                    32'h11111111, 32'h22222222, 32'h0, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 6'd7,  6'd7,  32'hAAAA0000, 32'hBBBB0000,
                    6'd7,  6'd3,  6'd40, 6'd7,
                    32'hBBBB0000, 32'h11111111, 32'h22222222, 32'hBBBB0000};
        vecs[4] = '{1'b0, 1'b0, 6'd9,  6'd7,  32'h12345678, 32'h1,
                    6'd9,  6'd7,  6'd3,  6'd9,
                    32'h0, 32'hBBBB0000, 32'h11111111, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 6'd50, 6'd1,  32'hFFFFFFFF, 32'h5,
                    6'd1,  6'd50, 6'd63, 6'd3,
                    32'h5, 32'h0, 32'h0, 32'h11111111};
        vecs[6] = '{1'b0, 1'b1, 6'd45, 6'd0,  32'hFFFFFFFF, 32'hABCDEF01,
                    6'd45, 6'd0,  6'd46, 6'd1,
                    32'hFFFFFFFF, 32'hABCDEF01, 32'h0, 32'h5};
        vecs[7] = '{1'b0, 1'b1, 6'd2,  6'd63, 32'h2, 32'h9,
                    6'd2,  6'd63, 6'd45, 6'd7,
                    32'h2, 32'h0, 32'hFFFFFFFF, 32'hBBBB0000};

        // Initial reset, then every address must read 0.
        do_edge(1'b1, 1'b0, '0, '0, '0, '0);
        do_edge(1'b1, 1'b0, '0, '0, '0, '0);
        for (int i = 0; i < int'(SPAN); i += 4) begin
            set_reads(AW'(i), AW'(i + 1), AW'(i + 2), AW'(i + 3));
            chk_model("reset_sweep");
        end

        for (int v = 0; v < 8; v++) begin
            do_edge(vecs[v].reset, vecs[v].wen, vecs[v].wa, vecs[v].da, vecs[v].wb, vecs[v].db);
            set_reads(vecs[v].ra, vecs[v].rb, vecs[v].rc, vecs[v].rd);
            chk($sformatf("vec%0d_a", v), qa, vecs[v].ea);
            chk($sformatf("vec%0d_b", v), qb, vecs[v].eb);
            chk($sformatf("vec%0d_c", v), qc, vecs[v].ec);
            chk($sformatf("vec%0d_d", v), qd, vecs[v].ed);
        end

        // Read-during-write: old value before the edge, new value after.
        do_edge(1'b0, 1'b1, 6'd10, 32'h1, 6'd44, 32'h0);
        @(negedge clk);
        rst = 1'b0; wen = 1'b1; wa = 6'd10; da = 32'h2; wb = 6'd44; db = 32'h0;
        set_reads(6'd10, 6'd10, 6'd10, 6'd10);
        chk("rdw_old_a", qa, 32'h1);
        chk("rdw_old_b", qb, 32'h1);
        chk("rdw_old_c", qc, 32'h1);
        chk("rdw_old_d", qd, 32'h1);
        @(posedge clk);
        model_edge();
        #1;
        chk("rdw_new_a", qa, 32'h2);
        chk("rdw_new_b", qb, 32'h2);
        chk("rdw_new_c", qc, 32'h2);
        chk("rdw_new_d", qd, 32'h2);
        // Address change alone, no edge in between, updates outputs.
        @(negedge clk);
        wen = 1'b0;
        set_reads(6'd3, 6'd40, 6'd7, 6'd1);
        chk("comb_a", qa, 32'h11111111);
        chk("comb_b", qb, 32'h22222222);
        chk("comb_c", qc, 32'hBBBB0000);
        chk("comb_d", qd, 32'h5);

        // Randomized traffic against the model.
        for (int it = 0; it < 600; it++) begin
            logic [AW-1:0] a_addr, b_addr;
            a_addr = AW'($urandom_range(0, 50));
            b_addr = ($urandom_range(0, 3) == 0) ? a_addr : AW'($urandom_range(0, 63));
            @(negedge clk);
            rst = ($urandom_range(0, 39) == 0);
            wen = ($urandom_range(0, 3) != 0);
            wa = a_addr; wb = b_addr; da = $urandom; db = $urandom;
            // Bias reads toward the write addresses to exercise read-during-write.
            set_reads(a_addr, b_addr, AW'($urandom_range(0, 63)), AW'($urandom_range(40, 50)));
            chk_model("rand_pre");
            @(posedge clk);
            model_edge();
            #1;
            chk_model("rand_post");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zap_register_file.md
Name: zap_register_file

Overview:
- Physical general-purpose register file for the ZAP ARM core. Instantiated inside the writeback stage.
- Provides four independent asynchronous read ports and two synchronous write ports that share one write enable.
- Holds all banked ARM registers (user, FIQ, IRQ, SVC, ABT, UND R13/R14, SPSRs, and a RAZ dump register) as PHY_REGS 32-bit entries.
- PC and CPSR are held outside this block.

Parameters:
- PHY_REGS, 46, number of physical 32-bit registers. Address width is AW = clog2(PHY_REGS) (6 at default).

Ports:
- i_clk  in  1  core clock; all state updates on its rising edge.
- i_reset  in  1  synchronous active-high reset.
- i_wr_addr_a  in  AW  write port A address.
- i_wr_addr_b  in  AW  write port B address.
- i_wr_data_a  in  32  write port A data.
- i_wr_data_b  in  32  write port B data.
- i_wen  in  1  common write enable for ports A and B.
- i_rd_addr_a  in  AW  read port A address.
- i_rd_addr_b  in  AW  read port B address.
- i_rd_addr_c  in  AW  read port C address.
- i_rd_addr_d  in  AW  read port D address.
- o_rd_data_a  out  32  read port A data.
- o_rd_data_b  out  32  read port B data.
- o_rd_data_c  out  32  read port C data.
- o_rd_data_d  out  32  read port D data.

Behaviour:
- Clocking: one clock, i_clk. Reset i_reset is synchronous and active-high.
- Storage: PHY_REGS x 32-bit flops, indices 0..PHY_REGS-1.
- Reset: on a rising edge with i_reset=1, every register clears to 32'h0. Writes are ignored in that cycle, whatever i_wen is.
- Write, i_reset=0 and i_wen=1 at the rising edge:
  - reg[i_wr_addr_a] <= i_wr_data_a.
  - reg[i_wr_addr_b] <= i_wr_data_b.
  - Both ports update in the same cycle.
- Write collision: if i_wr_addr_a == i_wr_addr_b with i_wen=1, port B data wins.
- Write disabled: with i_wen=0, no register changes.
- Out-of-range write: an address >= PHY_REGS on either port is ignored for that port only. The other port still writes.
- The RAZ dump register is an ordinary entry. Callers park unused write ports on it; the block applies no special handling.
- Reads: purely combinational, zero latency.
  - o_rd_data_x = reg[i_rd_addr_x], from current register contents.
  - The four ports are fully independent. Any or all may address the same register.
- Read-during-write: a read of an address being written in the same cycle returns the OLD value. The new value is visible after the clock edge. No internal write-to-read bypass; forwarding is done by the pipeline.
- Out-of-range read: an address >= PHY_REGS returns 32'h0.
- After reset, all read ports return 0 for every address until written.
- Reset mid-operation: a reset asserted together with i_wen=1 discards the write. All entries are 0 after that edge.
- No X propagation from unused entries: all entries are initialised by reset.

Test Plan:
- Reset clears: preload reg[5]=32'hDEADBEEF; assert i_reset one cycle with i_wen=1, addr_a=5 → all four ports read 0 at addr 5 and at addr 45.
- Dual write: i_wen=1, addr_a=3 data 32'h11111111, addr_b=40 data 32'h22222222, one edge → rd_a=3 gives 32'h11111111, rd_b=40 gives 32'h22222222, others unchanged.
- Collision: i_wen=1, addr_a=addr_b=7, data_a=32'hAAAA0000, data_b=32'hBBBB0000 → reg[7]=32'hBBBB0000.
- Write-enable low: i_wen=0 with addr_a=9 data 32'h12345678 → reg[9] keeps its previous value.
- Read-during-write and combinational read: reg[10]=32'h1; in the same cycle write 32'h2 to 10 and read 10 on all four ports.
  - Before the edge: ports show 32'h1.
  - After the edge: ports show 32'h2.
  - Changing rd addresses updates outputs with no clock.
- Out-of-range: write 32'hFFFFFFFF to addr 50 on port A and 32'h5 to addr 1 on port B → reg[1]=5, no register corrupted, and a read of 50 returns 0.
